// File: rtl/reg_wb_ctrl.sv
// Register-file writeback arbiter with an in-order load-rd queue and a pending-load scoreboard.
// Latency: an accepted ALU or load-response transfer is written to the RF one cycle later. Stall is combinational.
// Backpressure: ALU writes are held on WAW with a pending load. Loads are held when the queue is full or the rd is busy.
// The ALU wins arbitration until the load has been refused twice; the load then wins.
// Optional feature macro: RF_WB_FWD_EN (adds rs1_fwd/rs2_fwd and drops the write-match term from stall).
module reg_wb_ctrl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        ld_issue,
    output logic        ld_issue_ready,
    input  logic [4:0]  ld_rd,
    input  logic        ld_resp_valid,
    output logic        ld_resp_ready,
    input  logic [31:0] ld_resp_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef RF_WB_FWD_EN
    output logic        rs1_fwd,
    output logic        rs2_fwd,
`endif
    output logic        stall,
    output logic [31:0] busy
);

    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(LDQ_DEPTH);

    logic [4:0]    ldq_mem [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    starve;
    logic [31:0]   busy_nxt;
    logic [4:0]    head;

    logic q_empty, q_full, alu_hold, load_prio;
    logic alu_xfer, ld_xfer, push, wr_en;
    logic [4:0]  wr_addr_nxt;
    logic [31:0] wr_data_nxt;

    assign head      = ldq_mem[rd_ptr];
    assign q_empty   = (count == '0);
    assign q_full    = (count == FULL);
    assign alu_hold  = (alu_rd != 5'd0) && busy[alu_rd];
    // The starve counter only reaches 2 while a load is queued, so it also marks a pending response.
    assign load_prio = (starve == 2'd2);

    // Ready outputs come from registered state and valids only; alu_ready does not look at any ready.
    always_comb begin
        alu_ready      = !alu_hold && !load_prio;
        ld_issue_ready = !q_full && !((ld_rd != 5'd0) && busy[ld_rd]);
        ld_resp_ready  = !q_empty && (load_prio || !(alu_valid && alu_ready));
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_resp_valid && ld_resp_ready;
    assign push     = ld_issue && ld_issue_ready;

    // Select the single RF write for next cycle. The arbitration never grants both channels at once.
    always_comb begin
        wr_en       = 1'b0;
        wr_addr_nxt = 5'd0;
        wr_data_nxt = 32'd0;
        if (alu_xfer) begin
            wr_en       = (alu_rd != 5'd0);
            wr_addr_nxt = alu_rd;
            wr_data_nxt = alu_result;
        end else if (ld_xfer) begin
            wr_en       = (head != 5'd0);
            wr_addr_nxt = head;
            wr_data_nxt = ld_resp_data;
        end
    end

    // Update the scoreboard: clear the popped rd first, so a same-rd push overrides it.
    always_comb begin
        busy_nxt = busy;
        if (ld_xfer) busy_nxt[head] = 1'b0;
        if (push && (ld_rd != 5'd0)) busy_nxt[ld_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Registered writeback port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_addr_nxt;
                rf_wdata <= wr_data_nxt;
            end
        end
    end

    // Update queue pointers, count, scoreboard and starve counter. Reset drops every outstanding load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 32'd0;
            starve <= 2'd0;
        end else begin
            busy <= busy_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (ld_xfer) rd_ptr <= rd_ptr + 1'b1;
            if (push && !ld_xfer) count <= count + 1'b1;
            else if (!push && ld_xfer) count <= count - 1'b1;
            if (ld_xfer) starve <= 2'd0;
            else if (ld_resp_valid && !q_empty && alu_xfer && (starve != 2'd2)) starve <= starve + 2'd1;
        end
    end

    // Store queue entries. Only the pointers need reset.
    always_ff @(posedge clk) begin
        if (push) ldq_mem[wr_ptr] <= ld_rd;
    end

    // Flag decode-stage hazards against pending loads and against the write in flight.
`ifdef RF_WB_FWD_EN
    always_comb begin
        rs1_fwd = rf_we && (rs1_addr != 5'd0) && (rf_waddr == rs1_addr);
        rs2_fwd = rf_we && (rs2_addr != 5'd0) && (rf_waddr == rs2_addr);
        stall   = ((rs1_addr != 5'd0) && busy[rs1_addr]) ||
                  ((rs2_addr != 5'd0) && busy[rs2_addr]);
    end
`else
    always_comb begin
        stall = ((rs1_addr != 5'd0) && (busy[rs1_addr] || (rf_we && (rf_waddr == rs1_addr)))) ||
                ((rs2_addr != 5'd0) && (busy[rs2_addr] || (rf_we && (rf_waddr == rs2_addr))));
    end
`endif

endmodule
